// File: rtl/msu_volume_ramp_pkg.sv
// Shared widths and FSM encoding for the MSU volume ramp and the audio path that consumes it.
package msu_volume_ramp_pkg;

  localparam int unsigned VolW  = 8;
  localparam int unsigned PcmW  = 16;
  // Signed sample times a zero-extended 9-bit volume.
  localparam int unsigned ProdW = PcmW + VolW + 1;

  typedef enum logic [0:0] {
    MsuVrIdle = 1'b0,
    MsuVrRamp = 1'b1
  } msu_vr_state_e;

endpackage

// File: rtl/msu_vol_mult.sv
// One PCM channel: S1 captures the sample and the volume, S2 registers the scaled product.
module msu_vol_mult
  import msu_volume_ramp_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [PcmW-1:0] sample_i,
  input  logic [VolW-1:0] vol_i,
  output logic [PcmW-1:0] sample_o,
  output logic            valid_o
);

  logic                   s1_valid_q, s1_valid_d;
  logic signed [PcmW-1:0] s1_sample_q, s1_sample_d;
  logic [VolW-1:0]        s1_vol_q, s1_vol_d;
  logic [PcmW-1:0]        out_q, out_d;
  logic                   valid_q, valid_d;

  logic signed [ProdW-1:0] samp_ext;
  logic signed [ProdW-1:0] vol_ext;
  logic signed [ProdW-1:0] prod;

  assign samp_ext = ProdW'(s1_sample_q);
  assign vol_ext  = ProdW'($signed({1'b0, s1_vol_q}));
  assign prod     = samp_ext * vol_ext;

  always_comb begin
    s1_valid_d  = valid_i;
    s1_sample_d = s1_sample_q;
    s1_vol_d    = s1_vol_q;
    out_d       = out_q;
    valid_d     = s1_valid_q;
    if (valid_i) begin
      s1_sample_d = $signed(sample_i);
      s1_vol_d    = vol_i;
    end
    // Arithmetic shift floors toward minus infinity; the result always fits in PcmW bits.
    if (s1_valid_q) begin
      out_d = PcmW'(prod >>> VolW);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_sample_q <= '0;
      s1_vol_q    <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sample_q <= s1_sample_d;
      s1_vol_q    <= s1_vol_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
    end
  end

  assign sample_o = out_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/msu_volume_ramp.sv
// Latches MSU-1 volume writes as a target, ramps the applied volume one LSB per RAMP_DIV cycles,
// and scales the stereo PCM stream by the applied volume.
module msu_volume_ramp
  import msu_volume_ramp_pkg::*;
#(
  parameter int unsigned RAMP_DIV = 64
) (
  input  logic            clkin,
  input  logic            rst,
  input  logic [VolW-1:0] volume_in,
  input  logic            volume_latch,
  input  logic [PcmW-1:0] sample_in_l,
  input  logic [PcmW-1:0] sample_in_r,
  input  logic            sample_valid_in,
  output logic [PcmW-1:0] sample_out_l,
  output logic [PcmW-1:0] sample_out_r,
  output logic            sample_valid_out,
  output logic [VolW-1:0] current_volume,
  output logic            ramp_busy
);

  localparam int unsigned     DivW    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(RAMP_DIV - 1);

  msu_vr_state_e   state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [VolW-1:0] cur_q, cur_d;
  logic [VolW-1:0] tgt_q, tgt_d;
  logic            latch_q;
  logic            latch_edge;
  logic [VolW-1:0] step_vol;
  logic            valid_l, valid_r;

  assign latch_edge = volume_latch & ~latch_q;
  // Direction re-evaluated every step, so a mid-ramp reversal just works.
  assign step_vol   = (cur_q < tgt_q) ? cur_q + VolW'(1) : cur_q - VolW'(1);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      MsuVrIdle: begin
        if (latch_edge) begin
          tgt_d = volume_in;
          if (volume_in != cur_q) begin
            div_d   = '0;
            state_d = MsuVrRamp;
          end
        end
      end
      MsuVrRamp: begin
        if (latch_edge) begin
          tgt_d = volume_in;
          div_d = '0;
          if (volume_in == cur_q) begin
            state_d = MsuVrIdle;
          end
        end else if (div_q == DivLast) begin
          div_d = '0;
          cur_d = step_vol;
          if (step_vol == tgt_q) begin
            state_d = MsuVrIdle;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q <= MsuVrIdle;
      div_q   <= '0;
      cur_q   <= '0;
      tgt_q   <= '0;
      latch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      latch_q <= volume_latch;
    end
  end

  msu_vol_mult u_mult_l (
    .clk_i    (clkin),
    .rst_i    (rst),
    .valid_i  (sample_valid_in),
    .sample_i (sample_in_l),
    .vol_i    (cur_q),
    .sample_o (sample_out_l),
    .valid_o  (valid_l)
  );

  msu_vol_mult u_mult_r (
    .clk_i    (clkin),
    .rst_i    (rst),
    .valid_i  (sample_valid_in),
    .sample_i (sample_in_r),
    .vol_i    (cur_q),
    .sample_o (sample_out_r),
    .valid_o  (valid_r)
  );

  assign sample_valid_out = valid_l & valid_r;
  assign current_volume   = cur_q;
  assign ramp_busy        = (state_q == MsuVrRamp);

endmodule

// File: tb/tb_msu_volume_ramp.sv
// Randomized bench for msu_volume_ramp against a cycle-level behavioural model of the ramp and gain.
module tb_msu_volume_ramp;

  localparam int unsigned RampDiv = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  volume_in;
  logic        volume_latch;
  logic [15:0] sample_in_l, sample_in_r;
  logic        sample_valid_in;
  logic [15:0] sample_out_l, sample_out_r;
  logic        sample_valid_out;
  logic [7:0]  current_volume;
  logic        ramp_busy;

  always #5 clk = ~clk;

  msu_volume_ramp #(.RAMP_DIV(RampDiv)) dut (
    .clkin            (clk),
    .rst              (rst),
    .volume_in        (volume_in),
    .volume_latch     (volume_latch),
    .sample_in_l      (sample_in_l),
    .sample_in_r      (sample_in_r),
    .sample_valid_in  (sample_valid_in),
    .sample_out_l     (sample_out_l),
    .sample_out_r     (sample_out_r),
    .sample_valid_out (sample_valid_out),
    .current_volume   (current_volume),
    .ramp_busy        (ramp_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  int          m_cur, m_tgt, m_phase;
  bit          m_lprev;
  bit          m_v1, m_vo;
  logic [15:0] m_l1, m_r1, m_lo, m_ro;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Gain = floor(sample * vol / 256); e.g. 0x7FFF*255 -> 0x7F7F, 0x8000*255 -> 0x8080.
  function automatic logic [15:0] scale(input logic [15:0] s, input int vol);
    int p;
    p = int'($signed(s)) * vol;
    return 16'(p >>> 8);
  endfunction

  task automatic model_reset();
    m_cur = 0; m_tgt = 0; m_phase = 0; m_lprev = 1'b0;
    m_v1 = 1'b0; m_vo = 1'b0;
    m_l1 = '0; m_r1 = '0; m_lo = '0; m_ro = '0;
  endtask

  task automatic tick();
    bit rise;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      rise    = volume_latch && !m_lprev;
      m_lprev = volume_latch;
      if (m_v1) begin
        m_lo = m_l1;
        m_ro = m_r1;
      end
      m_vo = m_v1;
      m_v1 = sample_valid_in;
      if (sample_valid_in) begin
        m_l1 = scale(sample_in_l, m_cur);
        m_r1 = scale(sample_in_r, m_cur);
      end
      if (rise) begin
        m_tgt   = int'(volume_in);
        m_phase = 0;
      end else if (m_cur != m_tgt) begin
        m_phase++;
        if (m_phase == RampDiv) begin
          m_phase = 0;
          m_cur   = (m_cur < m_tgt) ? m_cur + 1 : m_cur - 1;
        end
      end
    end
    @(negedge clk);
    check_eq("cur_vol", 32'(current_volume), 32'(m_cur));
    check_eq("busy", 32'(ramp_busy), 32'(m_cur != m_tgt));
    check_eq("valid_out", 32'(sample_valid_out), 32'(m_vo));
    check_eq("out_l", 32'(sample_out_l), 32'(m_lo));
    check_eq("out_r", 32'(sample_out_r), 32'(m_ro));
  endtask

  task automatic rand_samples();
    sample_valid_in = 1'($urandom_range(0, 1));
    sample_in_l     = 16'($urandom);
    sample_in_r     = 16'($urandom);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      rand_samples();
      tick();
    end
  endtask

  task automatic pulse_latch(input logic [7:0] v, input int hold);
    volume_in    = v;
    volume_latch = 1'b1;
    for (int i = 0; i < hold; i++) begin
      rand_samples();
      tick();
    end
    volume_latch = 1'b0;
    rand_samples();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] pat [3];
    int          guard;
    pat[0] = 16'h7FFF; pat[1] = 16'h8000; pat[2] = 16'hFFFF;

    rst = 1'b1; volume_in = '0; volume_latch = 1'b0;
    sample_in_l = '0; sample_in_r = '0; sample_valid_in = 1'b0;
    model_reset();
    run(3);
    rst = 1'b0;

    // Muted at power-up
    sample_valid_in = 1'b1; sample_in_l = 16'h4000; sample_in_r = 16'h4000;
    tick();
    run(6);

    // Short ramp 0 -> 4, latch held several cycles
    pulse_latch(8'h04, 3);
    run(24);

    // Full-scale ramp and known products at vol 255
    pulse_latch(8'hFF, 1);
    guard = 0;
    while (m_cur != 255 && guard < 2000) begin
      run(1);
      guard++;
    end
    check_eq("settle_255", 32'(current_volume), 32'd255);
    for (int i = 0; i < 3; i++) begin
      sample_valid_in = 1'b1; sample_in_l = pat[i]; sample_in_r = pat[2 - i];
      tick();
    end
    sample_valid_in = 1'b0;
    run(4);

    // Reversal: ramp toward 0x10, re-latch 0x02 at current 6
    do_reset();
    pulse_latch(8'h10, 1);
    guard = 0;
    while (m_cur != 6 && guard < 200) begin
      run(1);
      guard++;
    end
    check_eq("reach_6", 32'(current_volume), 32'd6);
    pulse_latch(8'h02, 1);
    run(30);

    // Latch equal to current
    pulse_latch(8'h02, 2);
    run(8);

    // Reset mid-ramp with samples in flight
    pulse_latch(8'h80, 1);
    run(40);
    sample_valid_in = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(6);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 799) == 0);
      if (!volume_latch)
        volume_in = ($urandom_range(0, 3) == 0) ? 8'(m_cur) : 8'($urandom);
      volume_latch = ($urandom_range(0, 59) == 0) ? 1'b1 : (volume_latch & 1'($urandom_range(0, 1)));
      rand_samples();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
